// File: rtl/fetch_bus_alu_unit_pkg.sv
// Shared types and helpers for fetch_bus_alu_unit: bus cycle widths, ALU
// operations, cycle state, opcode constants and flag/alignment helpers.
package fetch_bus_alu_unit_pkg;

    // Bus cycle width as presented on mem_width
    typedef enum logic [1:0] {
        WIDTH_BYTE = 2'd0,
        WIDTH_WORD = 2'd1,
        WIDTH_LONG = 2'd2
    } width_e;

    // ALU operation codes; 13..15 produce a zero result
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_ADDC = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_SUBC = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOT  = 4'd7,
        ALU_LSL1 = 4'd8,
        ALU_LSR1 = 4'd9,
        ALU_ASR1 = 4'd10,
        ALU_COPY = 4'd11,
        ALU_NEG  = 4'd12
    } alu_op_e;

    // Bus cycle currently in progress
    typedef enum logic {
        CYC_FETCH = 1'b0,
        CYC_MEM   = 1'b1
    } cycle_e;

    localparam logic [5:0] OPC_HALT   = 6'h01;
    localparam logic [5:0] OPC_MEM_LO = 6'h10;
    localparam logic [5:0] OPC_MEM_HI = 6'h1F;

    // True when the opcode requests a following memory-stage cycle
    function automatic logic is_mem_opcode(input logic [5:0] opcode);
        return (opcode >= OPC_MEM_LO) && (opcode <= OPC_MEM_HI);
    endfunction

    // True when the access does not sit on its natural boundary
    function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] offset);
        logic mis;
        case (width)
            WIDTH_BYTE: mis = 1'b0;
            WIDTH_WORD: mis = offset[0];
            WIDTH_LONG: mis = (offset != 2'd0);
            default:    mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Signed overflow of a + b (+ carry): same-sign operands, result sign flips
    function automatic logic add_overflow(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] r);
        return (a[31] == b[31]) && (r[31] != a[31]);
    endfunction

    // Signed overflow of a - b (- borrow): opposite-sign operands, result sign differs from a
    function automatic logic sub_overflow(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] r);
        return (a[31] != b[31]) && (r[31] != a[31]);
    endfunction

endpackage

// File: rtl/fetch_bus_alu_unit_alu.sv
// Combinational ALU for fetch_bus_alu_unit: result plus carry/zero/negative/
// overflow flags. Subtract carry is a borrow.
module fetch_bus_alu_unit_alu
    import fetch_bus_alu_unit_pkg::*;
(
    input  logic [3:0]  alu_op,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic        carry_in,
    output logic [31:0] result,
    output logic        carry_out,
    output logic        zero_out,
    output logic        neg_out,
    output logic        over_out
);

    logic [32:0] wide_s;
    logic [31:0] result_s;
    logic        carry_s;
    logic        over_s;

    // Evaluate the selected operation and its carry/overflow
    always_comb begin
        wide_s   = 33'h0;
        result_s = 32'h0;
        carry_s  = 1'b0;
        over_s   = 1'b0;
        case (alu_op)
            ALU_ADD: begin
                wide_s   = {1'b0, operand_a} + {1'b0, operand_b};
                result_s = wide_s[31:0];
                carry_s  = wide_s[32];
                over_s   = add_overflow(operand_a, operand_b, wide_s[31:0]);
            end
            ALU_ADDC: begin
                wide_s   = {1'b0, operand_a} + {1'b0, operand_b} + {32'h0, carry_in};
                result_s = wide_s[31:0];
                carry_s  = wide_s[32];
                over_s   = add_overflow(operand_a, operand_b, wide_s[31:0]);
            end
            ALU_SUB: begin
                wide_s   = {1'b0, operand_a} - {1'b0, operand_b};
                result_s = wide_s[31:0];
                carry_s  = wide_s[32];
                over_s   = sub_overflow(operand_a, operand_b, wide_s[31:0]);
            end
            ALU_SUBC: begin
                wide_s   = {1'b0, operand_a} - {1'b0, operand_b} - {32'h0, carry_in};
                result_s = wide_s[31:0];
                carry_s  = wide_s[32];
                over_s   = sub_overflow(operand_a, operand_b, wide_s[31:0]);
            end
            ALU_AND:  result_s = operand_a & operand_b;
            ALU_OR:   result_s = operand_a | operand_b;
            ALU_XOR:  result_s = operand_a ^ operand_b;
            ALU_NOT:  result_s = ~operand_a;
            ALU_LSL1: begin
                result_s = {operand_a[30:0], 1'b0};
                carry_s  = operand_a[31];
            end
            ALU_LSR1: begin
                result_s = {1'b0, operand_a[31:1]};
                carry_s  = operand_a[0];
            end
            ALU_ASR1: begin
                result_s = {operand_a[31], operand_a[31:1]};
                carry_s  = operand_a[0];
            end
            ALU_COPY: result_s = operand_b;
            ALU_NEG: begin
                result_s = 32'h0 - operand_a;
                over_s   = sub_overflow(32'h0, operand_a, 32'h0 - operand_a);
            end
            default: result_s = 32'h0;
        endcase
    end

    assign result    = result_s;
    assign carry_out = carry_s;
    assign zero_out  = (result_s == 32'h0);
    assign neg_out   = result_s[31];
    assign over_out  = over_s;

endmodule

// File: rtl/fetch_bus_alu_unit.sv
// fetch_bus_alu_unit: instruction fetch sequencer, big-endian bus lane
// steering and ALU. A memory-class opcode inserts one memory cycle after its
// fetch; HALT stops fetching and raises halted after a short drain.
// Optional build macro BUS_ERROR_EN enables misaligned-access detection.
module fetch_bus_alu_unit
    import fetch_bus_alu_unit_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic        pc_inc,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_width,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    input  logic [3:0]  alu_op,
    input  logic [31:0] reg2,
    input  logic [31:0] reg3,
    input  logic [15:0] imm,
    input  logic        imm_cycle,
    input  logic        carry_in,
    output logic [31:0] alu_result,
    output logic        carry_out,
    output logic        zero_out,
    output logic        neg_out,
    output logic        over_out,
    output logic [29:0] address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic [3:0]  data_strobes,
    output logic        read,
    output logic        write,
    output logic        bus_error,
    output logic [31:0] instruction,
    output logic        block_fetch,
    output logic        halting,
    output logic        halted
);

    cycle_e      state_r;
    cycle_e      state_next_s;
    logic [31:0] instruction_r;
    logic        halting_r;
    logic [1:0]  halt_count_r;
    logic        halted_r;

    logic [31:0] operand_b_s;
    logic [31:0] alu_result_s;
    logic [31:0] eff_addr_s;
    logic [1:0]  eff_width_s;
    logic        read_req_s;
    logic        write_req_s;
    logic        pc_inc_s;
    logic [1:0]  offset_s;
    logic [3:0]  lanes_s;
    logic [31:0] store_lanes_s;
    logic [4:0]  load_shift_s;
    logic [31:0] load_mask_s;
    logic        bus_error_s;

    assign operand_b_s = imm_cycle ? {{16{imm[15]}}, imm} : reg3;

    fetch_bus_alu_unit_alu alu (
        .alu_op    (alu_op),
        .operand_a (reg2),
        .operand_b (operand_b_s),
        .carry_in  (carry_in),
        .result    (alu_result_s),
        .carry_out (carry_out),
        .zero_out  (zero_out),
        .neg_out   (neg_out),
        .over_out  (over_out)
    );

    // Cycle state register; reset abandons any memory cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= CYC_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next cycle: a latched memory-class opcode buys exactly one memory cycle
    always_comb begin
        state_next_s = CYC_FETCH;
        case (state_r)
            CYC_FETCH: begin
                if (!halting_r && is_mem_opcode(data_in[31:26])) begin
                    state_next_s = CYC_MEM;
                end else begin
                    state_next_s = CYC_FETCH;
                end
            end
            CYC_MEM:  state_next_s = CYC_FETCH;
            default:  state_next_s = CYC_FETCH;
        endcase
    end

    // Choose the effective access for this cycle (fetch or memory stage)
    always_comb begin
        eff_addr_s  = pc;
        eff_width_s = WIDTH_LONG;
        read_req_s  = 1'b1;
        write_req_s = 1'b0;
        pc_inc_s    = 1'b0;
        if (state_r == CYC_MEM) begin
            eff_addr_s  = alu_result_s;
            eff_width_s = mem_width;
            read_req_s  = mem_read;
            write_req_s = mem_write;
            pc_inc_s    = 1'b0;
        end else begin
            eff_addr_s  = pc;
            eff_width_s = WIDTH_LONG;
            read_req_s  = 1'b1;
            write_req_s = 1'b0;
            pc_inc_s    = ~halting_r;
        end
    end

    assign offset_s = eff_addr_s[1:0];

    // Big-endian lane steering: strobes, write replication, read extraction
    always_comb begin
        lanes_s       = 4'b0000;
        store_lanes_s = 32'h0;
        load_shift_s  = 5'd0;
        load_mask_s   = 32'h0;
        case (eff_width_s)
            WIDTH_BYTE: begin
                lanes_s       = 4'b1000 >> offset_s;
                store_lanes_s = {4{store_data[7:0]}};
                load_shift_s  = {~offset_s, 3'b000};
                load_mask_s   = 32'h0000_00FF;
            end
            WIDTH_WORD: begin
                lanes_s       = offset_s[1] ? 4'b0011 : 4'b1100;
                store_lanes_s = {2{store_data[15:0]}};
                load_shift_s  = offset_s[1] ? 5'd0 : 5'd16;
                load_mask_s   = 32'h0000_FFFF;
            end
            WIDTH_LONG: begin
                lanes_s       = 4'b1111;
                store_lanes_s = store_data;
                load_shift_s  = 5'd0;
                load_mask_s   = 32'hFFFF_FFFF;
            end
            default: begin
                lanes_s       = 4'b0000;
                store_lanes_s = 32'h0;
                load_shift_s  = 5'd0;
                load_mask_s   = 32'h0;
            end
        endcase
    end

`ifdef BUS_ERROR_EN
    assign bus_error_s = is_misaligned(eff_width_s, offset_s) & (read_req_s | write_req_s);
`else
    assign bus_error_s = 1'b0;
`endif

    // Drive bus handshake; a bus error suppresses the access entirely
    always_comb begin
        data_strobes = 4'b0000;
        read         = 1'b0;
        write        = 1'b0;
        if (bus_error_s) begin
            data_strobes = 4'b0000;
            read         = 1'b0;
            write        = 1'b0;
        end else begin
            data_strobes = lanes_s;
            read         = read_req_s;
            write        = write_req_s;
        end
    end

    // Latch fetched instruction; memory cycle retires it to a NOP
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instruction_r <= 32'h0;
        end else if (state_r == CYC_MEM) begin
            instruction_r <= 32'h0;
        end else if (!halting_r) begin
            instruction_r <= data_in;
        end else begin
            instruction_r <= instruction_r;
        end
    end

    // Sticky halting flag set when a HALT opcode is latched
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            halting_r <= 1'b0;
        end else if ((state_r == CYC_FETCH) && (data_in[31:26] == OPC_HALT)) begin
            halting_r <= 1'b1;
        end else begin
            halting_r <= halting_r;
        end
    end

    // Drain counter while halting; halted follows the cycle after it reaches 3
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            halt_count_r <= 2'd0;
            halted_r     <= 1'b0;
        end else if (halting_r) begin
            halt_count_r <= halt_count_r + 2'd1;
            halted_r     <= halted_r | (halt_count_r == 2'd3);
        end else begin
            halt_count_r <= halt_count_r;
            halted_r     <= halted_r;
        end
    end

    assign alu_result  = alu_result_s;
    assign address     = eff_addr_s[31:2];
    assign data_out    = (state_r == CYC_MEM) ? store_lanes_s : 32'h0;
    assign load_data   = (data_in >> load_shift_s) & load_mask_s;
    assign bus_error   = bus_error_s;
    assign pc_inc      = pc_inc_s;
    assign instruction = instruction_r;
    assign block_fetch = (state_r == CYC_MEM);
    assign halting     = halting_r;
    assign halted      = halted_r;

endmodule

// File: tb/tb_fetch_bus_alu_unit.sv
// Randomized scoreboard bench for fetch_bus_alu_unit with a behavioural model.
module tb_fetch_bus_alu_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        pc_inc;
    logic        mem_read, mem_write;
    logic [1:0]  mem_width;
    logic [31:0] store_data, load_data;
    logic [3:0]  alu_op;
    logic [31:0] reg2, reg3;
    logic [15:0] imm;
    logic        imm_cycle, carry_in;
    logic [31:0] alu_result;
    logic        carry_out, zero_out, neg_out, over_out;
    logic [29:0] address;
    logic [31:0] data_in, data_out;
    logic [3:0]  data_strobes;
    logic        read, write, bus_error;
    logic [31:0] instruction;
    logic        block_fetch, halting, halted;

    fetch_bus_alu_unit dut (
        .clock(clock), .reset(reset), .pc(pc), .pc_inc(pc_inc),
        .mem_read(mem_read), .mem_write(mem_write), .mem_width(mem_width),
        .store_data(store_data), .load_data(load_data), .alu_op(alu_op),
        .reg2(reg2), .reg3(reg3), .imm(imm), .imm_cycle(imm_cycle),
        .carry_in(carry_in), .alu_result(alu_result), .carry_out(carry_out),
        .zero_out(zero_out), .neg_out(neg_out), .over_out(over_out),
        .address(address), .data_in(data_in), .data_out(data_out),
        .data_strobes(data_strobes), .read(read), .write(write),
        .bus_error(bus_error), .instruction(instruction),
        .block_fetch(block_fetch), .halting(halting), .halted(halted)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] res;
        logic        c, z, n, o;
        logic [29:0] addr;
        logic [31:0] dout, ld;
        logic [3:0]  stb;
        logic        rd, wr, err, inc;
        logic [31:0] instr;
        logic        bf, hlt_ing, hlt_ed;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_pass  = 0;
    int   n_total = 0;

    // Architectural model state
    bit          m_mem, m_halting, m_halted;
    int          m_halt_cycles;
    logic [31:0] m_instr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    // Monitor: compare every presented cycle against the queued expectation
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("alu_result",   alu_result,          mon_e.res);
            chk("carry_out",    32'(carry_out),      32'(mon_e.c));
            chk("zero_out",     32'(zero_out),       32'(mon_e.z));
            chk("neg_out",      32'(neg_out),        32'(mon_e.n));
            chk("over_out",     32'(over_out),       32'(mon_e.o));
            chk("address",      32'(address),        32'(mon_e.addr));
            chk("data_out",     data_out,            mon_e.dout);
            chk("load_data",    load_data,           mon_e.ld);
            chk("data_strobes", 32'(data_strobes),   32'(mon_e.stb));
            chk("read",         32'(read),           32'(mon_e.rd));
            chk("write",        32'(write),          32'(mon_e.wr));
            chk("bus_error",    32'(bus_error),      32'(mon_e.err));
            chk("pc_inc",       32'(pc_inc),         32'(mon_e.inc));
            chk("instruction",  instruction,         mon_e.instr);
            chk("block_fetch",  32'(block_fetch),    32'(mon_e.bf));
            chk("halting",      32'(halting),        32'(mon_e.hlt_ing));
            chk("halted",       32'(halted),         32'(mon_e.hlt_ed));
        end
    end

    // Reference ALU computed with wide integer arithmetic
    task automatic alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic cin, output logic [31:0] r, output logic c, output logic o);
        longint ua, ub, sa, sb, s;
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = 32'h0; c = 1'b0; o = 1'b0;
        case (op)
            4'd0, 4'd1: begin
                s = ua + ub + ((op == 4'd1) ? longint'(cin) : 64'sd0);
                r = s[31:0]; c = s[32];
                s = sa + sb + ((op == 4'd1) ? longint'(cin) : 64'sd0);
                o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd2, 4'd3: begin
                s = (op == 4'd3) ? longint'(cin) : 64'sd0;
                r = a - b - s[31:0];
                c = (ua < ub + s);
                s = sa - sb - s;
                o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd4:  r = a & b;
            4'd5:  r = a | b;
            4'd6:  r = a ^ b;
            4'd7:  r = ~a;
            4'd8:  begin r = a << 1; c = a[31]; end
            4'd9:  begin r = a >> 1; c = a[0]; end
            4'd10: begin r = $signed(a) >>> 1; c = a[0]; end
            4'd11: r = b;
            4'd12: begin r = -a; o = (a == 32'h8000_0000); end
            default: r = 32'h0;
        endcase
    endtask

    // Queue the expectation for the current inputs, then advance the model one edge
    task automatic cycle();
        exp_t        e;
        logic [31:0] b, r, eff;
        logic        c, o;
        int          size, off, base, lane;
        bit          rq, wq, err, n_mem, n_halting, n_halted;
        int          n_hc;
        logic [31:0] n_instr;
        if (reset) begin
            m_mem = 0; m_halting = 0; m_halted = 0; m_halt_cycles = 0; m_instr = 32'h0;
        end
        b = imm_cycle ? {{16{imm[15]}}, imm} : reg3;
        alu_model(alu_op, reg2, b, carry_in, r, c, o);
        if (m_mem) begin
            eff = r; size = (mem_width == 2'd0) ? 1 : (mem_width == 2'd1) ? 2 : 4;
            rq = mem_read; wq = mem_write;
        end else begin
            eff = pc; size = 4; rq = 1; wq = 0;
        end
        off  = int'(eff[1:0]);
        base = off - (off % size);
        e.stb = 4'b0000; e.ld = 32'h0; e.dout = 32'h0;
        for (int k = 0; k < size; k++) begin
            lane = 3 - (base + k);
            e.stb[lane] = 1'b1;
            e.ld[8*(size-1-k) +: 8] = data_in[8*lane +: 8];
        end
        if (m_mem)
            for (int l = 0; l < 4; l++)
                e.dout[8*l +: 8] = store_data[8*(size-1-((3-l) % size)) +: 8];
`ifdef BUS_ERROR_EN
        err = ((off % size) != 0) && (rq || wq);
`else
        err = 0;
`endif
        if (err) begin e.stb = 4'b0000; rq = 0; wq = 0; end
        e.res = r; e.c = c; e.o = o; e.z = (r == 32'h0); e.n = r[31];
        e.addr = eff[31:2]; e.rd = rq; e.wr = wq; e.err = err;
        e.inc = !m_mem && !m_halting;
        e.instr = m_instr; e.bf = m_mem; e.hlt_ing = m_halting; e.hlt_ed = m_halted;
        exp_q.push_back(e);
        n_halting = m_halting; n_halted = m_halted; n_hc = m_halt_cycles;
        n_instr = m_instr; n_mem = 0;
        if (m_halting) begin
            n_hc++;
            if (n_hc >= 4) n_halted = 1;
        end
        if (m_mem) begin
            n_instr = 32'h0;
        end else if (!m_halting) begin
            n_instr = data_in;
            n_mem = (data_in[31:26] >= 6'h10) && (data_in[31:26] <= 6'h1F);
            if (data_in[31:26] == 6'h01) n_halting = 1;
        end
        @(posedge clock);
        #1;
        if (reset) begin
            m_mem = 0; m_halting = 0; m_halted = 0; m_halt_cycles = 0; m_instr = 32'h0;
        end else begin
            m_mem = n_mem; m_halting = n_halting; m_halted = n_halted;
            m_halt_cycles = n_hc; m_instr = n_instr;
        end
    endtask

    task automatic randomize_inputs();
        logic [5:0] opc;
        pc = $urandom; mem_read = 1'($urandom); mem_write = 1'($urandom);
        mem_width = 2'($urandom_range(0, 2)); store_data = $urandom;
        alu_op = 4'($urandom); reg2 = $urandom; reg3 = $urandom;
        imm = 16'($urandom); imm_cycle = 1'($urandom); carry_in = 1'($urandom);
        if ($urandom_range(0, 2) == 0) opc = 6'h10 + 6'($urandom_range(0, 15));
        else opc = 6'($urandom);
        if (opc == 6'h01) opc = 6'h00;
        data_in = {opc, 26'($urandom)};
    endtask

    task automatic mem_access(input logic [31:0] addr, input logic [1:0] w,
                              input logic rd, input logic wr, input logic [31:0] sd);
        randomize_inputs();
        data_in = {6'h10, 26'h0};
        cycle();
        randomize_inputs();
        alu_op = 4'd11; imm_cycle = 1'b0; reg3 = addr;
        mem_width = w; mem_read = rd; mem_write = wr; store_data = sd;
        cycle();
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        m_mem = 0; m_halting = 0; m_halted = 0; m_halt_cycles = 0; m_instr = 32'h0;
        reset = 1'b1;
        randomize_inputs();
        @(posedge clock);
        #1;
        cycle();
        cycle();
        reset = 1'b0;

        // ALU corner cases on plain fetch cycles
        randomize_inputs(); data_in = 32'h0;
        alu_op = 4'd0; reg2 = 32'h7FFF_FFFF; reg3 = 32'h1; imm_cycle = 1'b0;
        cycle();
        randomize_inputs(); data_in = 32'h0;
        alu_op = 4'd2; reg2 = 32'h0; reg3 = 32'h1; imm_cycle = 1'b0;
        cycle();
        randomize_inputs(); data_in = 32'h0;
        alu_op = 4'd0; reg2 = 32'h5; imm = 16'hFFFF; imm_cycle = 1'b1;
        cycle();
        randomize_inputs(); data_in = 32'h0;
        alu_op = 4'd12; reg2 = 32'h8000_0000;
        cycle();

        // Memory cycles: byte read, word store, misaligned long
        mem_access(32'h103, 2'd0, 1'b1, 1'b0, 32'h0);
        randomize_inputs(); data_in = 32'h0; cycle();
        mem_access(32'h102, 2'd1, 1'b0, 1'b1, 32'h0000_BEEF);
        mem_access(32'h101, 2'd2, 1'b1, 1'b0, 32'h1234_5678);
        mem_access(32'h101, 2'd1, 1'b1, 1'b0, 32'hCAFE_F00D);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            cycle();
        end

        // Reset asserted in the middle of a memory cycle
        randomize_inputs(); data_in = {6'h12, 26'h0};
        cycle();
        randomize_inputs(); reset = 1'b1;
        cycle();
        reset = 1'b0;
        randomize_inputs(); cycle();
        randomize_inputs(); cycle();

        // HALT: fetching stops, halted follows after the drain
        randomize_inputs(); data_in = 32'h0400_0000;
        cycle();
        for (int i = 0; i < 8; i++) begin
            randomize_inputs();
            cycle();
        end
        randomize_inputs(); reset = 1'b1;
        cycle();
        reset = 1'b0;
        randomize_inputs(); cycle();

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clock);
        n_total++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
